key_debounce: RTL and testbench



---
 rtl/key_debounce_pkg.sv | 15 +
 rtl/key_debounce_chan.sv | 60 ++++++
 rtl/key_debounce.sv | 33 +++
 tb/tb_key_debounce.sv | 199 +++++++++++++++++++
 4 files changed

// File: rtl/key_debounce_pkg.sv
// Shared constants and helpers for the push-button debouncer.
// KEY pins idle high, so "released" is the reset value of every per-key flop.
package key_debounce_pkg;

    localparam logic        KEY_RELEASED            = 1'b1;
    localparam int unsigned DEFAULT_DEBOUNCE_CYCLES = 500000;

    // Wide enough to hold 0..n-1; never narrower than one bit.
    function automatic int unsigned cnt_width(input int unsigned n);
        int unsigned w;
        w = $clog2(n);
        return (w < 1) ? 1 : w;
    endfunction

endpackage

// File: rtl/key_debounce_chan.sv
// One key channel: 2-flop synchroniser, saturating stability counter,
// debounced level and registered one-cycle press/release pulses.
module key_debounce_chan
    import key_debounce_pkg::*;
#(
    parameter int unsigned DEBOUNCE_CYCLES = DEFAULT_DEBOUNCE_CYCLES,
    parameter int unsigned CNT_W           = cnt_width(DEBOUNCE_CYCLES)
) (
    input  logic clk,
    input  logic reset_n,
    input  logic i_key_raw,
    output logic o_key_level,
    output logic o_key_press,
    output logic o_key_release
);

    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(DEBOUNCE_CYCLES - 1);

    logic             r_sync1;
    logic             r_sync2;
    logic             r_level;
    logic             r_press;
    logic             r_release;
    logic [CNT_W-1:0] r_cnt;
    logic             w_mismatch;

    assign w_mismatch = (r_sync2 != r_level);

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            r_sync1   <= KEY_RELEASED;
            r_sync2   <= KEY_RELEASED;
            r_level   <= KEY_RELEASED;
            r_cnt     <= '0;
            r_press   <= 1'b0;
            r_release <= 1'b0;
        end else begin
            r_sync1   <= i_key_raw;
            r_sync2   <= r_sync1;
            r_press   <= 1'b0;
            r_release <= 1'b0;
            // Any agreeing cycle restarts the count, so only an unbroken run is accepted.
            if (!w_mismatch) begin
                r_cnt <= '0;
            end else if (r_cnt != CNT_MAX) begin
                r_cnt <= r_cnt + CNT_W'(1);
            end else begin
                r_level   <= r_sync2;
                r_cnt     <= '0;
                r_press   <= ~r_sync2;
                r_release <= r_sync2;
            end
        end
    end

    assign o_key_level   = r_level;
    assign o_key_press   = r_press;
    assign o_key_release = r_release;

endmodule

// File: rtl/key_debounce.sv
// Debounces N_KEYS active-low push buttons ahead of the KEY PIO in_port.
// key_level keeps pin polarity (0 = pressed); press/release are 1-cycle pulses.
module key_debounce
    import key_debounce_pkg::*;
#(
    parameter int unsigned N_KEYS          = 2,
    parameter int unsigned DEBOUNCE_CYCLES = DEFAULT_DEBOUNCE_CYCLES
) (
    input  logic              clk,
    input  logic              reset_n,
    input  logic [N_KEYS-1:0] key_raw,
    output logic [N_KEYS-1:0] key_level,
    output logic [N_KEYS-1:0] key_press,
    output logic [N_KEYS-1:0] key_release
);

    localparam int unsigned CNT_W = cnt_width(DEBOUNCE_CYCLES);

    for (genvar g = 0; g < N_KEYS; g++) begin : g_chan
        key_debounce_chan #(
            .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES),
            .CNT_W           (CNT_W)
        ) u_chan (
            .clk           (clk),
            .reset_n       (reset_n),
            .i_key_raw     (key_raw[g]),
            .o_key_level   (key_level[g]),
            .o_key_press   (key_press[g]),
            .o_key_release (key_release[g])
        );
    end

endmodule

// File: tb/tb_key_debounce.sv
// Directed bench for key_debounce: DEBOUNCE_CYCLES=4 main instance plus a
// DEBOUNCE_CYCLES=2 instance to cover the minimum legal setting.
module tb_key_debounce;

    logic       clk = 1'b0;
    logic       reset_n;
    logic [1:0] key_raw;
    logic [1:0] key_level, key_press, key_release;
    logic [1:0] lvl_min, press_min, rel_min;
    int         errors = 0;
    int         checks = 0;

    always #5 clk = ~clk;

    key_debounce #(.N_KEYS(2), .DEBOUNCE_CYCLES(4)) dut (
        .clk         (clk),
        .reset_n     (reset_n),
        .key_raw     (key_raw),
        .key_level   (key_level),
        .key_press   (key_press),
        .key_release (key_release)
    );

    key_debounce #(.N_KEYS(2), .DEBOUNCE_CYCLES(2)) dut_min (
        .clk         (clk),
        .reset_n     (reset_n),
        .key_raw     (key_raw),
        .key_level   (lvl_min),
        .key_press   (press_min),
        .key_release (rel_min)
    );

    // Each call advances to just after the next rising edge; inputs set
    // before a call are captured by sync1 at that edge.
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        reset_n = 1'b0;
        key_raw = 2'b11;
        repeat (3) step();
        checks++;
        if (key_level !== 2'b11) begin
            errors++; $display("FAIL reset_level got=%b exp=11", key_level);
        end
        checks++;
        if (key_press !== 2'b00 || key_release !== 2'b00) begin
            errors++; $display("FAIL reset_pulses press=%b release=%b exp=00/00", key_press, key_release);
        end
        checks++;
        if (lvl_min !== 2'b11 || press_min !== 2'b00 || rel_min !== 2'b00) begin
            errors++; $display("FAIL reset_min level=%b press=%b release=%b exp=11/00/00", lvl_min, press_min, rel_min);
        end
        reset_n = 1'b1;
    endtask

    task automatic test_idle();
        for (int k = 0; k < 20; k++) begin
            step();
            checks++;
            if (key_level !== 2'b11 || key_press !== 2'b00 || key_release !== 2'b00) begin
                errors++;
                $display("FAIL idle k=%0d level=%b press=%b release=%b exp=11/00/00", k, key_level, key_press, key_release);
            end
        end
    endtask

    task automatic test_latency();
        logic [1:0] e_lvl, e_press, e_lvl_min, e_press_min;
        key_raw = 2'b10;
        for (int k = 0; k <= 6; k++) begin
            step();
            e_lvl       = (k >= 5) ? 2'b10 : 2'b11;
            e_press     = (k == 5) ? 2'b01 : 2'b00;
            e_lvl_min   = (k >= 3) ? 2'b10 : 2'b11;
            e_press_min = (k == 3) ? 2'b01 : 2'b00;
            checks++;
            if (key_level !== e_lvl || key_press !== e_press || key_release !== 2'b00) begin
                errors++;
                $display("FAIL latency edge=%0d level=%b exp=%b press=%b exp=%b release=%b exp=00",
                         k, key_level, e_lvl, key_press, e_press, key_release);
            end
            checks++;
            if (lvl_min !== e_lvl_min || press_min !== e_press_min || rel_min !== 2'b00) begin
                errors++;
                $display("FAIL latency_min edge=%0d level=%b exp=%b press=%b exp=%b release=%b exp=00",
                         k, lvl_min, e_lvl_min, press_min, e_press_min, rel_min);
            end
        end
    endtask

    task automatic test_bounce();
        logic [1:0] e_lvl, e_press;
        for (int c = 0; c < 40; c++) begin
            key_raw[1] = ((c / 2) % 2 == 0) ? 1'b0 : 1'b1;
            step();
            checks++;
            if (key_level !== 2'b10 || key_press !== 2'b00 || key_release !== 2'b00) begin
                errors++;
                $display("FAIL bounce c=%0d level=%b press=%b release=%b exp=10/00/00", c, key_level, key_press, key_release);
            end
        end
        key_raw[1] = 1'b0;
        for (int k = 0; k <= 6; k++) begin
            step();
            e_lvl   = (k >= 5) ? 2'b00 : 2'b10;
            e_press = (k == 5) ? 2'b10 : 2'b00;
            checks++;
            if (key_level !== e_lvl || key_press !== e_press || key_release !== 2'b00) begin
                errors++;
                $display("FAIL bounce_settle edge=%0d level=%b exp=%b press=%b exp=%b release=%b exp=00",
                         k, key_level, e_lvl, key_press, e_press, key_release);
            end
        end
    endtask

    task automatic test_simultaneous();
        logic [1:0] e_lvl, e_press, e_rel;
        // Release both, press both, release both again; each phase 10 cycles.
        for (int ph = 0; ph < 3; ph++) begin
            key_raw = (ph == 1) ? 2'b00 : 2'b11;
            for (int k = 0; k < 10; k++) begin
                step();
                e_lvl   = (k >= 5) ? key_raw : ~key_raw;
                e_press = (k == 5 && ph == 1) ? 2'b11 : 2'b00;
                e_rel   = (k == 5 && ph != 1) ? 2'b11 : 2'b00;
                checks++;
                if (key_level !== e_lvl || key_press !== e_press || key_release !== e_rel) begin
                    errors++;
                    $display("FAIL simul ph=%0d edge=%0d level=%b exp=%b press=%b exp=%b release=%b exp=%b",
                             ph, k, key_level, e_lvl, key_press, e_press, key_release, e_rel);
                end
            end
        end
    endtask

    task automatic test_glitch();
        logic [1:0] e_lvl, e_press, e_rel;
        // Three-sample glitch: one short of acceptance.
        for (int k = 0; k < 10; k++) begin
            key_raw = (k < 3) ? 2'b10 : 2'b11;
            step();
            checks++;
            if (key_level !== 2'b11 || key_press !== 2'b00 || key_release !== 2'b00) begin
                errors++;
                $display("FAIL glitch_short edge=%0d level=%b press=%b release=%b exp=11/00/00", k, key_level, key_press, key_release);
            end
        end
        // Four-sample pulse: accepted at edge 5, then released back at edge 9.
        for (int k = 0; k < 12; k++) begin
            key_raw = (k < 4) ? 2'b10 : 2'b11;
            step();
            e_lvl   = (k >= 5 && k < 9) ? 2'b10 : 2'b11;
            e_press = (k == 5) ? 2'b01 : 2'b00;
            e_rel   = (k == 9) ? 2'b01 : 2'b00;
            checks++;
            if (key_level !== e_lvl || key_press !== e_press || key_release !== e_rel) begin
                errors++;
                $display("FAIL glitch_exact edge=%0d level=%b exp=%b press=%b exp=%b release=%b exp=%b",
                         k, key_level, e_lvl, key_press, e_press, key_release, e_rel);
            end
        end
    endtask

    task automatic test_reset_mid_count();
        logic [1:0] e_lvl, e_press;
        key_raw = 2'b10;
        for (int k = 0; k <= 11; k++) begin
            reset_n = (k == 3 || k == 4) ? 1'b0 : 1'b1;
            step();
            e_lvl   = (k >= 10) ? 2'b10 : 2'b11;
            e_press = (k == 10) ? 2'b01 : 2'b00;
            checks++;
            if (key_level !== e_lvl || key_press !== e_press || key_release !== 2'b00) begin
                errors++;
                $display("FAIL reset_mid edge=%0d level=%b exp=%b press=%b exp=%b release=%b exp=00",
                         k, key_level, e_lvl, key_press, e_press, key_release);
            end
        end
        reset_n = 1'b1;
    endtask

    initial begin
        reset_n = 1'b0;
        key_raw = 2'b11;
        test_reset();
        test_idle();
        test_latency();
        test_bounce();
        test_simultaneous();
        test_glitch();
        test_reset_mid_count();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
